button_event_decoder: RTL and testbench

- Consumes the debounced level from the switch debouncer in the same clock domain and turns it into single-cycle event pulses for the game/control FSMs.
- Events: press, release, short click, long press and optional auto-repeat while held.
- Sits directly downstream of the debouncer, one instance per button.

---
 rtl/button_event_decoder.sv | 113 +++++++++++
 tb/tb_button_event_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long/repeat pulses; all outputs registered, 1 clock after the deciding edge.
// Optional auto-repeat while held is built only when BUTTON_EVENT_DECODER_REPEAT_EN is defined; no backpressure, pulses are fire-and-forget.
module button_event_decoder #(
    parameter int c_LONG_PRESS_CYCLES = 12500000,
    parameter int c_REPEAT_CYCLES     = 2500000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Short,
    output logic o_Long,
    output logic o_Repeat,
    output logic o_Held
);

    localparam int c_MAX_CYCLES = (c_LONG_PRESS_CYCLES > c_REPEAT_CYCLES) ?
                                  c_LONG_PRESS_CYCLES : c_REPEAT_CYCLES;
    localparam int CW = $clog2(c_MAX_CYCLES + 1);

    localparam logic [CW-1:0] c_LONG_CNT = CW'(c_LONG_PRESS_CYCLES);
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
    localparam logic [CW-1:0] c_REP_CNT  = CW'(c_REPEAT_CYCLES);
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    state_t          r_State;
    logic            r_Prev;
    logic [CW-1:0]   r_Count;

`ifndef BUTTON_EVENT_DECODER_REPEAT_EN
    assign o_Repeat = 1'b0;
`endif

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_State   <= IDLE;
            r_Prev    <= 1'b0;
            r_Count   <= '0;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Short   <= 1'b0;
            o_Long    <= 1'b0;
            o_Held    <= 1'b0;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
            o_Repeat  <= 1'b0;
`endif
        end else begin
            r_Prev    <= i_Switch;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Short   <= 1'b0;
            o_Long    <= 1'b0;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
            o_Repeat  <= 1'b0;
`endif
            case (r_State)
                IDLE: begin
                    if (i_Switch && !r_Prev) begin
                        o_Press <= 1'b1;
                        o_Held  <= 1'b1;
                        r_Count <= CW'(1);
                        r_State <= PRESSED;
                    end
                end
                PRESSED: begin
                    // Release is checked first so it wins over a coinciding long-press edge.
                    if (!i_Switch) begin
                        o_Release <= 1'b1;
                        o_Short   <= 1'b1;
                        o_Held    <= 1'b0;
                        r_Count   <= '0;
                        r_State   <= IDLE;
                    end else if (r_Count == c_LONG_CNT) begin
                        o_Long  <= 1'b1;
                        r_Count <= CW'(1);
                        r_State <= HELD;
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
                end
                HELD: begin
                    if (!i_Switch) begin
                        o_Release <= 1'b1;
                        o_Held    <= 1'b0;
                        r_Count   <= '0;
                        r_State   <= IDLE;
                    end
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
                    else if (r_Count == c_REP_CNT) begin
                        o_Repeat <= 1'b1;
                        r_Count  <= CW'(1);
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
`endif
                end
                default: begin
                    o_Held  <= 1'b0;
                    r_Count <= '0;
                    r_State <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with long=8, repeat=4; expectations hand-derived per edge index k (edge E+k).
module tb_button_event_decoder;

    logic i_Clk;
    logic i_Reset;
    logic i_Switch;
    logic o_Press, o_Release, o_Short, o_Long, o_Repeat, o_Held;

    int tests;
    int fails;

`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    button_event_decoder #(
        .c_LONG_PRESS_CYCLES(8),
        .c_REPEAT_CYCLES    (4)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Switch (i_Switch),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_Short  (o_Short),
        .o_Long   (o_Long),
        .o_Repeat (o_Repeat),
        .o_Held   (o_Held)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Output vector order: {press, release, short, long, repeat, held}
    function automatic logic [5:0] outs();
        return {o_Press, o_Release, o_Short, o_Long, o_Repeat, o_Held};
    endfunction

    task automatic edge_with(input logic sw);
        i_Switch = sw;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) edge_with(1'b0);
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        i_Reset  = 1'b1;
        i_Switch = 1'b0;
        @(posedge i_Clk);
        @(posedge i_Clk);
        #1;
        obs = outs();
        tests++;
        if (obs !== 6'b0) begin
            fails++;
            $display("FAIL reset_state: got %b expected %b", obs, 6'b0);
        end
        i_Reset = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_short_click();
        logic [5:0] obs, exp;
        for (int k = 0; k < 5; k++) begin
            edge_with(k < 3);
            exp = {k == 0, k == 3, k == 3, 1'b0, 1'b0, k < 3};
            obs = outs();
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL short_click k=%0d: got %b expected %b", k, obs, exp);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_long_hold();
        logic [5:0] obs, exp;
        for (int k = 0; k < 20; k++) begin
            edge_with(k < 18);
            exp = {k == 0, k == 18, 1'b0, k == 8, REP && (k == 12 || k == 16), k < 18};
            obs = outs();
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL long_hold k=%0d: got %b expected %b", k, obs, exp);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_release_at_long_edge();
        logic [5:0] obs, exp;
        for (int k = 0; k < 10; k++) begin
            edge_with(k < 8);
            exp = {k == 0, k == 8, k == 8, 1'b0, 1'b0, k < 8};
            obs = outs();
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL release_at_long k=%0d: got %b expected %b", k, obs, exp);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_release_at_repeat_edge();
        logic [5:0] obs, exp;
        for (int k = 0; k < 14; k++) begin
            edge_with(k < 12);
            exp = {k == 0, k == 12, 1'b0, k == 8, 1'b0, k < 12};
            obs = outs();
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL release_at_repeat k=%0d: got %b expected %b", k, obs, exp);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs, exp;
        logic [5:0] pat;
        pat = 6'b001011;
        for (int k = 0; k < 6; k++) begin
            edge_with(pat[k]);
            exp = {k == 0 || k == 3, k == 2 || k == 4, k == 2 || k == 4, 1'b0, 1'b0,
                   k == 0 || k == 1 || k == 3};
            obs = outs();
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL back_to_back k=%0d: got %b expected %b", k, obs, exp);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_hold();
        logic [5:0] obs, exp;
        for (int k = 0; k <= 10; k++) begin
            edge_with(1'b1);
            exp = {k == 0, 1'b0, 1'b0, k == 8, 1'b0, 1'b1};
            obs = outs();
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL mid_hold_pre k=%0d: got %b expected %b", k, obs, exp);
            end
        end
        i_Reset = 1'b1;
        #1;
        obs = outs();
        tests++;
        if (obs !== 6'b0) begin
            fails++;
            $display("FAIL reset_async_clear: got %b expected %b", obs, 6'b0);
        end
        @(posedge i_Clk);
        #1;
        obs = outs();
        tests++;
        if (obs !== 6'b0) begin
            fails++;
            $display("FAIL reset_held_clear: got %b expected %b", obs, 6'b0);
        end
        i_Reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            edge_with(k < 10);
            exp = {k == 0, k == 10, 1'b0, k == 8, 1'b0, k < 10};
            obs = outs();
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL post_reset k=%0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        i_Reset  = 1'b1;
        i_Switch = 1'b0;
        test_reset();
        test_short_click();
        test_long_hold();
        test_release_at_long_edge();
        test_release_at_repeat_edge();
        test_back_to_back();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
